// File: rtl/led_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// led_ctrl_pkg
// Shared types and helpers for the LED chaser controller.
//   mode_e      : pattern mode encoding (FWD, REV, PING, BLINK)
//   speed_t     : speed index, step period = BASE_PERIOD >> speed
//   dir_e       : ping-pong travel direction
//   deb_cycles  : debounce length in clk cycles from clock rate and ms
// ---------------------------------------------------------------------------
package led_ctrl_pkg;

  localparam int MODE_W  = 2;
  localparam int SPEED_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_FWD   = 2'd0,
    MODE_REV   = 2'd1,
    MODE_PING  = 2'd2,
    MODE_BLINK = 2'd3
  } mode_e;

  typedef logic [SPEED_W-1:0] speed_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Clamped to 1 so a very slow clock still gives a working debouncer.
  function automatic int deb_cycles(input int clk_hz, input int debounce_ms);
    int c;
    c = (clk_hz / 1000) * debounce_ms;
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/led_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// led_seq_ctrl_if
// Board-side signal bundle of the LED chaser controller.
//   btn_mode_n/btn_speed_n/btn_pause_n : raw active-low pushbuttons
//   led    : LED drive, 1 = on
//   mode   : current pattern mode
//   speed  : current speed index
//   paused : 1 = sequence frozen
// master = board/stimulus side, slave = controller side.
// ---------------------------------------------------------------------------
interface led_seq_ctrl_if #(
  parameter int NUM_LEDS = 3
);
  import led_ctrl_pkg::*;

  logic                btn_mode_n;
  logic                btn_speed_n;
  logic                btn_pause_n;
  logic [NUM_LEDS-1:0] led;
  logic [MODE_W-1:0]   mode;
  speed_t              speed;
  logic                paused;

  modport master (
    output btn_mode_n, btn_speed_n, btn_pause_n,
    input  led, mode, speed, paused
  );

  modport slave (
    input  btn_mode_n, btn_speed_n, btn_pause_n,
    output led, mode, speed, paused
  );

endinterface

// File: rtl/led_seq_ctrl_btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Synchronises one asynchronous active-low button, debounces it and emits a
// single-cycle event on each debounced press.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   btn_n     : raw button, active-low, asynchronous to clk
//   pressed   : debounced level, 1 = pressed
//   press_evt : one-cycle pulse on released->pressed
// ---------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEB_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic pressed,
  output logic press_evt
);

  localparam int CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

  logic             sync1_q, sync2_q;
  logic             pressed_q, pressed_d;
  logic             evt_q, evt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             raw_pressed;

  assign raw_pressed = ~sync2_q;

  // The count only advances while the synchronised level disagrees with the
  // debounced level; any agreement (a bounce back) restarts it.
  always_comb begin
    pressed_d = pressed_q;
    evt_d     = 1'b0;
    cnt_d     = '0;
    if (raw_pressed != pressed_q) begin
      if (cnt_q == CNT_W'(DEB_CYC - 1)) begin
        pressed_d = raw_pressed;
        evt_d     = raw_pressed;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchronisers reset to the released level so leaving reset never
  // looks like a press edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      pressed_q <= 1'b0;
      evt_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= btn_n;
      sync2_q   <= sync1_q;
      pressed_q <= pressed_d;
      evt_q     <= evt_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pressed   = pressed_q;
  assign press_evt = evt_q;

endmodule

// File: rtl/led_seq_ctrl.sv
// ---------------------------------------------------------------------------
// led_seq_ctrl
// Configurable LED chaser: three debounced buttons select pattern mode,
// step speed and pause; a tick counter paces the pattern sequencer.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : led_seq_ctrl_if.slave (buttons in; led/mode/speed/paused out)
// ---------------------------------------------------------------------------
module led_seq_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int NUM_LEDS    = 3,
  parameter int DEBOUNCE_MS = 20,
  parameter int BASE_PERIOD = 25_000_000
) (
  input  logic          clk,
  input  logic          rst_n,
  led_seq_ctrl_if.slave bus
);

  localparam int DEB_CYC = deb_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int CNT_W   = $clog2(BASE_PERIOD);
  localparam int POS_W   = $clog2(NUM_LEDS);

  logic       mode_evt, speed_evt, pause_evt;
  logic [2:0] btn_level_unused;

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_mode (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_n     (bus.btn_mode_n),
    .pressed   (btn_level_unused[0]),
    .press_evt (mode_evt)
  );

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_speed (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_n     (bus.btn_speed_n),
    .pressed   (btn_level_unused[1]),
    .press_evt (speed_evt)
  );

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_pause (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_n     (bus.btn_pause_n),
    .pressed   (btn_level_unused[2]),
    .press_evt (pause_evt)
  );

  mode_e               mode_q, mode_d;
  speed_t              speed_q, speed_d;
  logic                paused_q, paused_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  dir_e                dir_q, dir_d;
  logic                phase_q, phase_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic [CNT_W-1:0]    period_m1;
  logic                step;

  function automatic logic [NUM_LEDS-1:0] led_decode(input mode_e m,
                                                     input logic [POS_W-1:0] p,
                                                     input logic ph);
    logic [NUM_LEDS-1:0] one;
    one = NUM_LEDS'(1);
    if (m == MODE_BLINK) return ph ? '0 : '1;
    return one << p;
  endfunction

  assign period_m1 = CNT_W'((BASE_PERIOD >> speed_q) - 1);
  assign step      = (cnt_q == period_m1) && !paused_q;

  always_comb begin
    mode_d   = mode_q;
    speed_d  = speed_q;
    paused_d = paused_q;
    pos_d    = pos_q;
    dir_d    = dir_q;
    phase_d  = phase_q;
    cnt_d    = cnt_q;

    if (speed_evt) speed_d  = speed_q + 1'b1;
    if (pause_evt) paused_d = ~paused_q;

    // Counter holds while paused so unpause resumes mid-period.
    if (mode_evt || speed_evt || step) cnt_d = '0;
    else if (!paused_q)                cnt_d = cnt_q + 1'b1;

    // A mode press restarts the pattern and swallows a coincident step.
    if (mode_evt) begin
      mode_d  = mode_e'(mode_q + 1'b1);
      pos_d   = '0;
      dir_d   = DIR_UP;
      phase_d = 1'b0;
    end else if (step) begin
      case (mode_q)
        MODE_FWD:
          pos_d = (pos_q == POS_W'(NUM_LEDS - 1)) ? '0 : pos_q + 1'b1;
        MODE_REV:
          pos_d = (pos_q == '0) ? POS_W'(NUM_LEDS - 1) : pos_q - 1'b1;
        MODE_PING: begin
          // Bounce at the ends without repeating the end LED.
          if (dir_q == DIR_UP) begin
            if (pos_q == POS_W'(NUM_LEDS - 1)) begin
              dir_d = DIR_DOWN;
              pos_d = POS_W'(NUM_LEDS - 2);
            end else begin
              pos_d = pos_q + 1'b1;
            end
          end else begin
            if (pos_q == '0) begin
              dir_d = DIR_UP;
              pos_d = POS_W'(1);
            end else begin
              pos_d = pos_q - 1'b1;
            end
          end
        end
        MODE_BLINK:
          phase_d = ~phase_q;
      endcase
    end

    // Decoding the next state keeps led in step with pos/phase.
    led_d = led_decode(mode_d, pos_d, phase_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= MODE_FWD;
      speed_q  <= '0;
      paused_q <= 1'b0;
      pos_q    <= '0;
      dir_q    <= DIR_UP;
      phase_q  <= 1'b0;
      cnt_q    <= '0;
      led_q    <= NUM_LEDS'(1);
    end else begin
      mode_q   <= mode_d;
      speed_q  <= speed_d;
      paused_q <= paused_d;
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      led_q    <= led_d;
    end
  end

  assign bus.led    = led_q;
  assign bus.mode   = mode_q;
  assign bus.speed  = speed_q;
  assign bus.paused = paused_q;

endmodule
